// File: rtl/md_scheduler.sv
// md_scheduler: fixed-latency multiply/divide sequencer with HI/LO registers.
// Results commit on the last busy edge; stall holds MDU users in D.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES =
        (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    op;
    logic [31:0]   a;
    logic [31:0]   b;

    logic          e_is_md;
    logic          accept;
    logic          commit;
    logic          hi_we;
    logic          lo_we;
    logic [31:0]   hi_new;
    logic [31:0]   lo_new;

    logic          op_signed;
    logic          a_neg;
    logic          b_neg;
    logic [63:0]   prod;
    logic [31:0]   ua;
    logic [31:0]   ub;
    logic [31:0]   dvsr;
    logic [31:0]   uq;
    logic [31:0]   ur;
    logic [31:0]   quot;
    logic [31:0]   rem;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE -> RUN on accepted mult/div, RUN -> IDLE on last count
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (commit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch and down-counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
            op  <= '0;
            a   <= '0;
            b   <= '0;
        end else if (accept) begin
            op <= E_md_op;
            a  <= E_A;
            b  <= E_B;
            if (E_md_op == OP_MULT || E_md_op == OP_MULTU) begin
                cnt <= CW'(MULT_CYCLES);
            end else begin
                cnt <= CW'(DIV_CYCLES);
            end
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Arithmetic on magnitudes so signed corner cases need no special path;
    // a zero divisor is replaced by 1 here and the commit is suppressed.
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = op_signed & a[31];
        b_neg     = op_signed & b[31];
        prod      = {{32{a_neg}}, a} * {{32{b_neg}}, b};
        ua        = a_neg ? (32'd0 - a) : a;
        ub        = b_neg ? (32'd0 - b) : b;
        dvsr      = (ub == 32'd0) ? 32'd1 : ub;
        uq        = ua / dvsr;
        ur        = ua % dvsr;
        quot      = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem       = a_neg ? (32'd0 - ur) : ur;
    end

    // Outputs: busy, stall, accept/commit strobes and HI/LO write selects
    always_comb begin
        e_is_md = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU);
        busy    = (state == RUN);
        stall   = D_md_use & (busy | (E_start & e_is_md));
        accept  = (state == IDLE) & E_start & e_is_md;
        commit  = (state == RUN) & (cnt == CW'(1));
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        hi_new  = hi;
        lo_new  = lo;
        if (state == IDLE && E_start) begin
            if (E_md_op == OP_MTHI) begin
                hi_we  = 1'b1;
                hi_new = E_A;
            end
            if (E_md_op == OP_MTLO) begin
                lo_we  = 1'b1;
                lo_new = E_A;
            end
        end
        if (commit) begin
            unique case (1'b1)
                (op == OP_MULT || op == OP_MULTU): begin
                    hi_we  = 1'b1;
                    lo_we  = 1'b1;
                    hi_new = prod[63:32];
                    lo_new = prod[31:0];
                end
                (op == OP_DIV || op == OP_DIVU): begin
                    if (b != 32'd0) begin
                        hi_we  = 1'b1;
                        lo_we  = 1'b1;
                        hi_new = rem;
                        lo_new = quot;
                    end
                end
                default: begin
                    hi_we = 1'b0;
                    lo_we = 1'b0;
                end
            endcase
        end
    end

    // HI/LO registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_new;
            if (lo_we) lo <= lo_new;
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed table of MDU ops plus stall, overlap
// and reset sequences for md_scheduler.
module tb_md_scheduler;
    logic        clk;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_md_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    vec_t tbl [0:14];

    md_scheduler #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .E_start (E_start),
        .E_md_op (E_md_op),
        .E_A     (E_A),
        .E_B     (E_B),
        .D_md_use(D_md_use),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one op at the current negedge, accept at the next posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        E_start = 1'b1;
        E_md_op = op;
        E_A     = a;
        E_B     = b;
        @(posedge clk);
        #1;
        E_start = 1'b0;
        E_md_op = 3'd0;
    endtask

    // Count cycles with busy high; returns at first negedge with busy low.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        int n;
        tbl[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,
                    32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        tbl[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001, 5};
        tbl[2]  = '{3'd5, 32'h00000011, 32'd0,
                    32'h00000011, 32'h00000001, 0};
        tbl[3]  = '{3'd6, 32'h00000022, 32'd0,
                    32'h00000011, 32'h00000022, 0};
        tbl[4]  = '{3'd4, 32'd7, 32'd0,
                    32'h00000011, 32'h00000022, 10};
        tbl[5]  = '{3'd3, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF,
                    32'h00000000, 32'h80000000, 10};
        tbl[7]  = '{3'd3, 32'd7, 32'hFFFFFFFE,
                    32'h00000001, 32'hFFFFFFFD, 10};
        tbl[8]  = '{3'd4, 32'hFFFFFFFF, 32'd10,
                    32'h00000005, 32'h19999999, 10};
        tbl[9]  = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF,
                    32'h3FFFFFFF, 32'h00000001, 5};
        tbl[10] = '{3'd6, 32'hCAFEBABE, 32'd0,
                    32'h3FFFFFFF, 32'hCAFEBABE, 0};
        tbl[11] = '{3'd7, 32'h00001234, 32'd5,
                    32'h3FFFFFFF, 32'hCAFEBABE, 0};
        tbl[12] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'h00000000, 32'h00000001, 5};
        tbl[13] = '{3'd2, 32'h80000000, 32'd2,
                    32'h00000001, 32'h00000000, 5};
        tbl[14] = '{3'd3, 32'hFFFFFFF8, 32'hFFFFFFFD,
                    32'hFFFFFFFE, 32'h00000002, 10};

        reset    = 1'b0;
        E_start  = 1'b0;
        E_md_op  = 3'd0;
        E_A      = '0;
        E_B      = '0;
        D_md_use = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i <= 14; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            count_busy(n);
            check($sformatf("v%0d_busy_cycles", i), 32'(n),
                  32'(tbl[i].n));
            check($sformatf("v%0d_hi", i), hi, tbl[i].hi);
            check($sformatf("v%0d_lo", i), lo, tbl[i].lo);
        end

        // mthi with mflo in D: no mult/div issued, so no stall
        D_md_use = 1'b1;
        E_start  = 1'b1;
        E_md_op  = 3'd5;
        E_A      = 32'h55;
        #1;
        check("mthi_no_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        E_start = 1'b0;
        @(negedge clk);

        // div 100/7 with mflo held in D
        E_start = 1'b1;
        E_md_op = 3'd3;
        E_A     = 32'd100;
        E_B     = 32'd7;
        #1;
        check("stall_issue", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        E_start = 1'b0;
        E_md_op = 3'd0;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        check("stall_cycles", 32'(n), 32'd10);
        check("stall_free_lo", lo, 32'd14);
        check("stall_free_hi", hi, 32'd2);
        D_md_use = 1'b0;

        // mult then mthi issued during RUN must be ignored
        issue(3'd3, 32'd20, 32'd3);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            E_start = (n == 3) || (n == 4);
            E_md_op = (n == 3) ? 3'd1 : 3'd5;
            E_A     = (n == 3) ? 32'd5 : 32'h0000DEAD;
            E_B     = 32'd5;
        end
        E_start = 1'b0;
        E_md_op = 3'd0;
        check("overlap_busy_cycles", 32'(n), 32'd10);
        check("overlap_hi", hi, 32'd2);
        check("overlap_lo", lo, 32'd6);
        @(negedge clk);
        check("overlap_no_restart", {31'd0, busy}, 32'd0);

        // reset in cycle 3 of a div aborts it
        issue(3'd3, 32'd9, 32'd2);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);
        check("abort_late_busy", {31'd0, busy}, 32'd0);

        // reset and start in the same cycle: reset wins
        reset   = 1'b0;
        E_start = 1'b1;
        E_md_op = 3'd1;
        E_A     = 32'd3;
        E_B     = 32'd4;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        E_start = 1'b0;
        E_md_op = 3'd0;
        count_busy(n);
        check("rst_start_busy", 32'(n), 32'd0);
        check("rst_start_lo", lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
